io_step_gen: RTL and testbench

IO_STEP_GEN -- requirements
Module: io_step_gen

---
 rtl/io_step_pkg.sv | 21 ++
 rtl/io_dwell_cnt.sv | 28 ++
 rtl/io_step_gen.sv | 198 +++++++++++++++++++
 tb/tb_io_step_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_step_pkg.sv
// Shared definitions for the DLX reset/step pulse generator.
// Holds the FSM state encoding, the MODE encodings and the default reset pulse length.
package io_step_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RST  = 3'd1,
      S_RGAP = 3'd2,
      S_HIGH = 3'd3,
      S_LOW  = 3'd4,
      S_FIN  = 3'd5
   } state_e;

   localparam logic [1:0] MODE_SINGLE  = 2'b00;
   localparam logic [1:0] MODE_BURST   = 2'b01;
   localparam logic [1:0] MODE_FREE    = 2'b10;
   localparam logic [1:0] MODE_RSTONLY = 2'b11;

   localparam int RST_LEN_DEF = 4;

endpackage

// File: rtl/io_dwell_cnt.sv
// Loadable down-counter that times how long the generator dwells in a state.
// A load of N makes o_expire true in the N-th cycle after the load edge.
module io_dwell_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_expire
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt > CNT_W'(1)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // Parks at 1 (or 0 after reset) so a stalled state still sees expire.
   assign o_expire = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/io_step_gen.sv
// Drives the DLX RESET_IN/STEP_IN pins: optional reset pulse, then single,
// burst or free-running step pulses with programmable high and gap lengths.
module io_step_gen
   import io_step_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int STEPS_W = 16,
   parameter int RST_LEN = RST_LEN_DEF
) (
   input  logic               CLK_IN,
   input  logic               RESET_IN,
   input  logic               START,
   input  logic               ABORT,
   input  logic [1:0]         MODE,
   input  logic               DO_RESET,
   input  logic [CNT_W-1:0]   HI_LEN,
   input  logic [CNT_W-1:0]   LO_LEN,
   input  logic [STEPS_W-1:0] STEP_CNT,
   input  logic               STOP_N,
   output logic               RESET_OUT,
   output logic               STEP_OUT,
   output logic               BUSY,
   output logic               DONE,
   output logic               HALTED,
   output logic [STEPS_W-1:0] STEPS_DONE
);

   state_e             r_state;
   state_e             w_next;

   logic [1:0]         r_mode;
   logic [CNT_W-1:0]   r_hi_len;
   logic [CNT_W-1:0]   r_lo_len;
   logic [STEPS_W-1:0] r_step_cnt;

   logic               r_stop_seen;
   logic               r_halted;
   logic [STEPS_W-1:0] r_steps_done;
   logic               r_reset_out;
   logic               r_step_out;
   logic               r_busy;
   logic               r_done;

   logic               w_accept;
   logic               w_in_step;
   logic               w_stop_now;
   logic               w_expire;
   logic               w_load;
   logic [CNT_W-1:0]   w_load_val;
   logic [CNT_W-1:0]   w_hi_in;
   logic [CNT_W-1:0]   w_lo_in;
   logic [STEPS_W-1:0] w_steps_inc;

   assign w_hi_in     = (HI_LEN == '0) ? CNT_W'(1) : HI_LEN;
   assign w_lo_in     = (LO_LEN == '0) ? CNT_W'(1) : LO_LEN;
   assign w_accept    = (r_state == S_IDLE) && START && !ABORT;
   assign w_in_step   = (r_state == S_HIGH) || (r_state == S_LOW);
   assign w_stop_now  = r_stop_seen || (w_in_step && !STOP_N);
   assign w_steps_inc = (&r_steps_done) ? r_steps_done : r_steps_done + STEPS_W'(1);

   io_dwell_cnt #(
      .CNT_W (CNT_W)
   ) u_dwell (
      .i_clk      (CLK_IN),
      .i_rst      (RESET_IN),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_expire   (w_expire)
   );

   // NOTE: every signal assigned in this block gets a default first, so no latch is inferred.
   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_load_val = r_lo_len;
      if (r_state != S_IDLE && ABORT) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (DO_RESET || MODE == MODE_RSTONLY) begin
                     w_next     = S_RST;
                     w_load     = 1'b1;
                     w_load_val = CNT_W'(RST_LEN);
                  end else if (MODE == MODE_BURST && STEP_CNT == '0) begin
                     w_next = S_FIN;
                  end else begin
                     w_next     = S_HIGH;
                     w_load     = 1'b1;
                     w_load_val = w_hi_in;
                  end
               end
            end
            S_RST: begin
               if (w_expire) begin
                  w_next     = S_RGAP;
                  w_load     = 1'b1;
                  w_load_val = r_lo_len;
               end
            end
            S_RGAP: begin
               if (w_expire) begin
                  if (r_mode == MODE_RSTONLY || (r_mode == MODE_BURST && r_step_cnt == '0)) begin
                     w_next = S_FIN;
                  end else begin
                     w_next     = S_HIGH;
                     w_load     = 1'b1;
                     w_load_val = r_hi_len;
                  end
               end
            end
            S_HIGH: begin
               if (w_expire) begin
                  w_next     = S_LOW;
                  w_load     = 1'b1;
                  w_load_val = r_lo_len;
               end
            end
            S_LOW: begin
               if (w_expire) begin
                  // A halt request always wins once the gap has run out.
                  if (w_stop_now) begin
                     w_next = S_FIN;
                  end else begin
                     case (r_mode)
                        MODE_SINGLE: w_next = S_FIN;
                        MODE_BURST:  w_next = (r_steps_done == r_step_cnt) ? S_FIN : S_HIGH;
                        MODE_FREE:   w_next = S_HIGH;
                        default:     w_next = S_FIN;
                     endcase
                     if (w_next == S_HIGH) begin
                        w_load     = 1'b1;
                        w_load_val = r_hi_len;
                     end
                  end
               end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // NOTE: the sequence configuration is always written by START before it is read, so it carries no reset.
   always_ff @(posedge CLK_IN) begin
      if (w_accept) begin
         r_mode     <= MODE;
         r_hi_len   <= w_hi_in;
         r_lo_len   <= w_lo_in;
         r_step_cnt <= STEP_CNT;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge CLK_IN) begin
      if (RESET_IN) begin
         r_state      <= S_IDLE;
         r_stop_seen  <= 1'b0;
         r_halted     <= 1'b0;
         r_steps_done <= '0;
         r_reset_out  <= 1'b0;
         r_step_out   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state     <= w_next;
         // Pin drives follow the next state so they line up with it cycle-for-cycle.
         r_reset_out <= (w_next == S_RST);
         r_step_out  <= (w_next == S_HIGH);
         r_busy      <= (w_next != S_IDLE);
         r_done      <= (w_next == S_FIN);
         if (w_accept) begin
            r_stop_seen  <= 1'b0;
            r_halted     <= 1'b0;
            r_steps_done <= '0;
         end else begin
            if (w_in_step && !STOP_N) begin
               r_stop_seen <= 1'b1;
            end
            if (r_state == S_HIGH && w_next == S_LOW) begin
               r_steps_done <= w_steps_inc;
            end
            if (r_state == S_LOW && w_next == S_FIN && w_stop_now) begin
               r_halted <= 1'b1;
            end
         end
      end
   end

   assign RESET_OUT  = r_reset_out;
   assign STEP_OUT   = r_step_out;
   assign BUSY       = r_busy;
   assign DONE       = r_done;
   assign HALTED     = r_halted;
   assign STEPS_DONE = r_steps_done;

endmodule

// File: tb/tb_io_step_gen.sv
// Directed bench for io_step_gen: per-cycle pin traces are captured into bit
// vectors and compared against hand-derived waveforms.
module tb_io_step_gen;

   logic        clk;
   logic        rst_in, start, abort, do_reset, stop_n;
   logic [1:0]  mode;
   logic [7:0]  hi_len, lo_len;
   logic [15:0] step_cnt;
   logic        reset_out, step_out, busy, done, halted;
   logic [15:0] steps_done;

   logic        rst_in2, start2, abort2, do_reset2, stop_n2;
   logic [1:0]  mode2;
   logic [3:0]  hi_len2, lo_len2, step_cnt2;
   logic        reset_out2, step_out2, busy2, done2, halted2;
   logic [3:0]  steps_done2;

   logic [63:0] cap_rst, cap_step, cap_done, cap_busy;
   int          n_checks = 0;
   int          n_fail   = 0;

   io_step_gen dut (
      .CLK_IN(clk), .RESET_IN(rst_in), .START(start), .ABORT(abort), .MODE(mode),
      .DO_RESET(do_reset), .HI_LEN(hi_len), .LO_LEN(lo_len), .STEP_CNT(step_cnt),
      .STOP_N(stop_n), .RESET_OUT(reset_out), .STEP_OUT(step_out), .BUSY(busy),
      .DONE(done), .HALTED(halted), .STEPS_DONE(steps_done)
   );

   io_step_gen #(.CNT_W(4), .STEPS_W(4)) dut2 (
      .CLK_IN(clk), .RESET_IN(rst_in2), .START(start2), .ABORT(abort2), .MODE(mode2),
      .DO_RESET(do_reset2), .HI_LEN(hi_len2), .LO_LEN(lo_len2), .STEP_CNT(step_cnt2),
      .STOP_N(stop_n2), .RESET_OUT(reset_out2), .STEP_OUT(step_out2), .BUSY(busy2),
      .DONE(done2), .HALTED(halted2), .STEPS_DONE(steps_done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] rng(input int lo, input int hi);
      logic [63:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   task automatic start_seq(input logic [1:0] md, input logic dr, input logic [7:0] hi,
                            input logic [7:0] lo, input logic [15:0] cnt);
      mode = md; do_reset = dr; hi_len = hi; lo_len = lo; step_cnt = cnt;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Index i of each vector is the i-th cycle after the START edge.
   task automatic capture(input int n, input int stop_at, input int abort_at,
                          input int start_at, input int rstin_at);
      cap_rst = '0; cap_step = '0; cap_done = '0; cap_busy = '0;
      for (int i = 0; i < n; i++) begin
         cap_rst[i]  = reset_out;
         cap_step[i] = step_out;
         cap_done[i] = done;
         cap_busy[i] = busy;
         stop_n = (i == stop_at) ? 1'b0 : 1'b1;
         abort  = (i == abort_at);
         start  = (i == start_at);
         rst_in = (i == rstin_at);
         @(posedge clk); #1;
      end
      stop_n = 1'b1; abort = 1'b0; start = 1'b0; rst_in = 1'b0;
   endtask

   task automatic test_reset;
      rst_in = 1'b1; rst_in2 = 1'b1;
      start = 0; abort = 0; mode = 0; do_reset = 0; hi_len = 0; lo_len = 0; step_cnt = 0; stop_n = 1;
      start2 = 0; abort2 = 0; mode2 = 0; do_reset2 = 0; hi_len2 = 0; lo_len2 = 0; step_cnt2 = 0; stop_n2 = 1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({reset_out, step_out, busy, done, halted} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 00000", {reset_out, step_out, busy, done, halted});
      end
      n_checks++;
      if (steps_done !== 16'd0) begin
         n_fail++; $display("FAIL reset_steps: got %0d expected 0", steps_done);
      end
      n_checks++;
      if ({reset_out2, step_out2, busy2, done2, halted2, steps_done2} !== 9'b0) begin
         n_fail++; $display("FAIL reset_dut2: got %b expected 0", {reset_out2, step_out2, busy2, done2, halted2, steps_done2});
      end
      rst_in = 1'b0; rst_in2 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single;
      start_seq(2'b00, 1'b1, 8'd4, 8'd8, 16'd0);
      capture(28, -1, -1, -1, -1);
      n_checks++;
      if (cap_rst !== rng(0, 3)) begin
         n_fail++; $display("FAIL single_rst: got %h expected %h", cap_rst, rng(0, 3));
      end
      n_checks++;
      if (cap_step !== rng(12, 15)) begin
         n_fail++; $display("FAIL single_step: got %h expected %h", cap_step, rng(12, 15));
      end
      n_checks++;
      if (cap_done !== rng(24, 24) || cap_busy !== rng(0, 24)) begin
         n_fail++; $display("FAIL single_done_busy: got %h/%h expected %h/%h", cap_done, cap_busy, rng(24, 24), rng(0, 24));
      end
      n_checks++;
      if ((cap_rst & cap_step) !== 64'd0) begin
         n_fail++; $display("FAIL single_overlap: got %h expected 0", cap_rst & cap_step);
      end
      n_checks++;
      if (steps_done !== 16'd1 || halted !== 1'b0) begin
         n_fail++; $display("FAIL single_steps: got %0d/%b expected 1/0", steps_done, halted);
      end
      // Reset-only mode: 4-cycle reset, 1-cycle gap, then FIN.
      start_seq(2'b11, 1'b0, 8'd2, 8'd1, 16'd0);
      capture(8, -1, -1, -1, -1);
      n_checks++;
      if (cap_rst !== rng(0, 3) || cap_step !== 64'd0 || cap_done !== rng(5, 5)) begin
         n_fail++; $display("FAIL rstonly_wave: got %h/%h/%h expected %h/0/%h", cap_rst, cap_step, cap_done, rng(0, 3), rng(5, 5));
      end
      n_checks++;
      if (steps_done !== 16'd0) begin
         n_fail++; $display("FAIL rstonly_steps: got %0d expected 0", steps_done);
      end
   endtask

   task automatic test_burst;
      logic [63:0] exp_step;
      start_seq(2'b01, 1'b0, 8'd2, 8'd0, 16'd3);
      hi_len = 8'd9; mode = 2'b10;
      capture(12, -1, -1, 4, -1);
      exp_step = rng(0, 1) | rng(3, 4) | rng(6, 7);
      n_checks++;
      if (cap_step !== exp_step) begin
         n_fail++; $display("FAIL burst_step: got %h expected %h", cap_step, exp_step);
      end
      n_checks++;
      if (cap_done !== rng(9, 9) || cap_busy !== rng(0, 9)) begin
         n_fail++; $display("FAIL burst_done_busy: got %h/%h expected %h/%h", cap_done, cap_busy, rng(9, 9), rng(0, 9));
      end
      n_checks++;
      if (steps_done !== 16'd3) begin
         n_fail++; $display("FAIL burst_steps: got %0d expected 3", steps_done);
      end
      start_seq(2'b01, 1'b0, 8'd2, 8'd0, 16'd0);
      capture(4, -1, -1, -1, -1);
      n_checks++;
      if (cap_step !== 64'd0 || cap_done !== rng(0, 0) || cap_busy !== rng(0, 0)) begin
         n_fail++; $display("FAIL burst_zero: got %h/%h/%h expected 0/1/1", cap_step, cap_done, cap_busy);
      end
      n_checks++;
      if (steps_done !== 16'd0) begin
         n_fail++; $display("FAIL burst_zero_steps: got %0d expected 0", steps_done);
      end
   endtask

   task automatic test_free_run_halt;
      logic [63:0] exp_step;
      start_seq(2'b10, 1'b0, 8'd1, 8'd2, 16'd0);
      capture(18, 12, -1, -1, -1);
      exp_step = rng(0, 0) | rng(3, 3) | rng(6, 6) | rng(9, 9) | rng(12, 12);
      n_checks++;
      if (cap_step !== exp_step) begin
         n_fail++; $display("FAIL halt_step: got %h expected %h", cap_step, exp_step);
      end
      n_checks++;
      if (cap_done !== rng(15, 15) || cap_busy !== rng(0, 15)) begin
         n_fail++; $display("FAIL halt_done_busy: got %h/%h expected %h/%h", cap_done, cap_busy, rng(15, 15), rng(0, 15));
      end
      n_checks++;
      if (steps_done !== 16'd5 || halted !== 1'b1) begin
         n_fail++; $display("FAIL halt_status: got %0d/%b expected 5/1", steps_done, halted);
      end
   endtask

   task automatic test_reset_mid_op;
      rst_in = 1'b1;
      @(posedge clk); #1;
      rst_in = 1'b0;
      n_checks++;
      if (halted !== 1'b0 || steps_done !== 16'd0) begin
         n_fail++; $display("FAIL idle_reset_status: got %b/%0d expected 0/0", halted, steps_done);
      end
      start_seq(2'b00, 1'b1, 8'd3, 8'd1, 16'd0);
      capture(5, -1, -1, -1, 1);
      n_checks++;
      if (cap_rst !== rng(0, 1) || cap_busy !== rng(0, 1) || cap_step !== 64'd0 || cap_done !== 64'd0) begin
         n_fail++; $display("FAIL midop_reset: got %h/%h/%h/%h expected %h/%h/0/0", cap_rst, cap_busy, cap_step, cap_done, rng(0, 1), rng(0, 1));
      end
      start_seq(2'b00, 1'b0, 8'd3, 8'd1, 16'd0);
      capture(7, -1, -1, -1, -1);
      n_checks++;
      if (cap_step !== rng(0, 2) || cap_done !== rng(4, 4) || cap_rst !== 64'd0) begin
         n_fail++; $display("FAIL post_reset_run: got %h/%h/%h expected %h/%h/0", cap_step, cap_done, cap_rst, rng(0, 2), rng(4, 4));
      end
      n_checks++;
      if (steps_done !== 16'd1) begin
         n_fail++; $display("FAIL post_reset_steps: got %0d expected 1", steps_done);
      end
   endtask

   task automatic test_abort;
      start_seq(2'b01, 1'b0, 8'd2, 8'd1, 16'd4);
      capture(8, -1, 3, -1, -1);
      n_checks++;
      if (cap_step !== (rng(0, 1) | rng(3, 3)) || cap_busy !== rng(0, 3)) begin
         n_fail++; $display("FAIL abort_wave: got %h/%h expected %h/%h", cap_step, cap_busy, rng(0, 1) | rng(3, 3), rng(0, 3));
      end
      n_checks++;
      if (cap_done !== 64'd0) begin
         n_fail++; $display("FAIL abort_done: got %h expected 0", cap_done);
      end
      n_checks++;
      if (steps_done !== 16'd1 || halted !== 1'b0) begin
         n_fail++; $display("FAIL abort_status: got %0d/%b expected 1/0", steps_done, halted);
      end
      mode = 2'b00; do_reset = 1'b0; hi_len = 8'd2;
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      n_checks++;
      if ({busy, step_out, reset_out} !== 3'b000) begin
         n_fail++; $display("FAIL start_abort_idle: got %b expected 000", {busy, step_out, reset_out});
      end
   endtask

   task automatic test_param_sweep;
      int pulses = 0;
      int run = 0;
      int bad = 0;
      bit done_seen = 1'b0;
      mode2 = 2'b10; do_reset2 = 1'b0; hi_len2 = 4'd15; lo_len2 = 4'd1; step_cnt2 = 4'd0;
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int c = 0; c < 600 && !done_seen; c++) begin
         if (step_out2) begin
            run++;
         end else if (run != 0) begin
            pulses++;
            if (run != 15) bad++;
            run = 0;
         end
         if (done2) done_seen = 1'b1;
         stop_n2 = !(step_out2 && pulses == 19);
         @(posedge clk); #1;
      end
      stop_n2 = 1'b1;
      n_checks++;
      if (!done_seen) begin
         n_fail++; $display("FAIL sweep_timeout: got no DONE expected DONE within 600 cycles");
      end
      n_checks++;
      if (pulses !== 20 || bad !== 0) begin
         n_fail++; $display("FAIL sweep_pulses: got %0d pulses, %0d wrong width expected 20, 0", pulses, bad);
      end
      n_checks++;
      if (steps_done2 !== 4'd15 || halted2 !== 1'b1) begin
         n_fail++; $display("FAIL sweep_saturate: got %0d/%b expected 15/1", steps_done2, halted2);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_free_run_halt();
      test_reset_mid_op();
      test_abort();
      test_param_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
